// File: rtl/lockout_controller.sv
// lockout_controller: supervisory sequencer beside the digital lock FSM.
// It counts consecutive failed entries and, once maxAttempts is reached,
// imposes a timed lockout. Each lockout is twice as long as the previous
// one, up to maxLockoutSeconds. After a correct entry it holds the lock open
// for unlockHoldSeconds. Leaving either timed state issues a one-cycle
// relockPulse, which re-arms the lock FSM.
//
// Handshake: attemptDone is a single-cycle strobe and is only acted on in
// ARMED. There is no ready/back-pressure; strobes seen in UNLOCKED or
// LOCKOUT are dropped. attemptPass is meaningful only while attemptDone is
// high.
//
// Every output is a flop. stateCode mirrors the FSM state, so checkers can
// observe it directly.
module lockout_controller #(
  parameter int clockFrequency     = 50000000,
  parameter int maxAttempts        = 3,
  parameter int baseLockoutSeconds = 5,
  parameter int maxLockoutSeconds  = 80,
  parameter int unlockHoldSeconds  = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       attemptDone,
  input  logic       attemptPass,
  input  logic       relockRequest,
  output logic       keyEnable,
  output logic       unlocked,
  output logic       lockout,
  output logic       relockPulse,
  output logic [3:0] failCount,
  output logic [7:0] remainingSeconds,
  output logic [1:0] stateCode
);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  // A divide-by-1 prescaler still needs one bit of storage.
  localparam int PW = (clockFrequency > 1) ? $clog2(clockFrequency) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(clockFrequency - 1);
  localparam logic [PW-1:0] PRESCALE_ONE  = PW'(1);
  localparam logic [4:0]    FAIL_LIMIT    = 5'(maxAttempts);
  localparam logic [15:0]   LOCKOUT_BASE  = 16'(baseLockoutSeconds);
  localparam logic [15:0]   LOCKOUT_CAP   = 16'(maxLockoutSeconds);
  localparam logic [7:0]    HOLD_SECONDS  = 8'(unlockHoldSeconds);

  state_t         state;
  logic [PW-1:0]  prescaler;
  logic [2:0]     lockout_level;

  logic           tick;
  logic [15:0]    shifted_len;
  logic [7:0]     lockout_len;
  logic [4:0]     fail_next;
  logic           timer_last;

  // Combinational helpers: one-second tick and the escalated lockout length.
  // The 16-bit shift cannot wrap for a level of up to 7, so the saturating
  // compare always sees the true product.
  always_comb begin
    tick        = (prescaler == PRESCALE_LAST);
    shifted_len = LOCKOUT_BASE << lockout_level;
    lockout_len = (shifted_len > LOCKOUT_CAP) ? LOCKOUT_CAP[7:0] : shifted_len[7:0];
    fail_next   = {1'b0, failCount} + 5'd1;
    timer_last  = (remainingSeconds <= 8'd1);
  end

  // Main sequencer. It updates state, counters and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= ARMED;
      prescaler        <= '0;
      lockout_level    <= 3'd0;
      keyEnable        <= 1'b1;
      unlocked         <= 1'b0;
      lockout          <= 1'b0;
      relockPulse      <= 1'b0;
      failCount        <= 4'd0;
      remainingSeconds <= 8'd0;
      stateCode        <= ARMED;
    end else begin
      relockPulse <= 1'b0;
      case (state)
        ARMED: begin
          prescaler <= '0;
          if (attemptDone) begin
            if (attemptPass) begin
              state            <= UNLOCKED;
              stateCode        <= UNLOCKED;
              keyEnable        <= 1'b0;
              unlocked         <= 1'b1;
              lockout          <= 1'b0;
              remainingSeconds <= HOLD_SECONDS;
              failCount        <= 4'd0;
              lockout_level    <= 3'd0;
            end else if (fail_next < FAIL_LIMIT) begin
              failCount <= fail_next[3:0];
            end else begin
              state            <= LOCKOUT;
              stateCode        <= LOCKOUT;
              keyEnable        <= 1'b0;
              unlocked         <= 1'b0;
              lockout          <= 1'b1;
              remainingSeconds <= lockout_len;
              failCount        <= 4'd0;
              if (lockout_level != 3'd7) begin
                lockout_level <= lockout_level + 3'd1;
              end
            end
          end
        end

        UNLOCKED: begin
          // An early relock request takes priority over a same-cycle tick,
          // so exactly one pulse is issued on the way out.
          if (relockRequest || (tick && timer_last)) begin
            state            <= ARMED;
            stateCode        <= ARMED;
            keyEnable        <= 1'b1;
            unlocked         <= 1'b0;
            lockout          <= 1'b0;
            relockPulse      <= 1'b1;
            remainingSeconds <= 8'd0;
            prescaler        <= '0;
          end else if (tick) begin
            remainingSeconds <= remainingSeconds - 8'd1;
            prescaler        <= '0;
          end else begin
            prescaler <= prescaler + PRESCALE_ONE;
          end
        end

        LOCKOUT: begin
          // relockRequest is deliberately ignored. lockout_level is kept,
          // so the next lockout is longer until a correct entry occurs.
          if (tick && timer_last) begin
            state            <= ARMED;
            stateCode        <= ARMED;
            keyEnable        <= 1'b1;
            unlocked         <= 1'b0;
            lockout          <= 1'b0;
            relockPulse      <= 1'b1;
            remainingSeconds <= 8'd0;
            prescaler        <= '0;
          end else if (tick) begin
            remainingSeconds <= remainingSeconds - 8'd1;
            prescaler        <= '0;
          end else begin
            prescaler <= prescaler + PRESCALE_ONE;
          end
        end

        default: begin
          // Illegal encoding: fall back to ARMED quietly, without a pulse.
          state            <= ARMED;
          stateCode        <= ARMED;
          keyEnable        <= 1'b1;
          unlocked         <= 1'b0;
          lockout          <= 1'b0;
          remainingSeconds <= 8'd0;
          prescaler        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lockout_controller.sv
// tb_lockout_controller: directed bench for lockout_controller using small
// timing parameters (10 clocks per second).
// Inputs change just after a falling edge. Outputs are sampled on falling
// edges, halfway between active edges.
module tb_lockout_controller;

  localparam int CLK_HZ = 10;

  logic       clock;
  logic       reset;
  logic       attemptDone;
  logic       attemptPass;
  logic       relockRequest;
  logic       keyEnable;
  logic       unlocked;
  logic       lockout;
  logic       relockPulse;
  logic [3:0] failCount;
  logic [7:0] remainingSeconds;
  logic [1:0] stateCode;

  int checks;
  int errors;

  lockout_controller #(
    .clockFrequency    (CLK_HZ),
    .maxAttempts       (3),
    .baseLockoutSeconds(5),
    .maxLockoutSeconds (80),
    .unlockHoldSeconds (10)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .attemptDone     (attemptDone),
    .attemptPass     (attemptPass),
    .relockRequest   (relockRequest),
    .keyEnable       (keyEnable),
    .unlocked        (unlocked),
    .lockout         (lockout),
    .relockPulse     (relockPulse),
    .failCount       (failCount),
    .remainingSeconds(remainingSeconds),
    .stateCode       (stateCode)
  );

  // Clock and reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog: the bench ends even if a fault stalls the FSM.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Driver: one-cycle attemptDone strobe. The call starts just after a
  // falling edge and returns on the next one, with the result visible.
  task automatic attempt(input logic pass);
    attemptDone = 1'b1;
    attemptPass = pass;
    @(negedge clock);
    attemptDone = 1'b0;
    attemptPass = 1'b0;
  endtask

  task automatic relock_once();
    relockRequest = 1'b1;
    @(negedge clock);
    relockRequest = 1'b0;
  endtask

  // Three fails, then a full lockout of len seconds, ending in a relock pulse.
  task automatic do_lockout(input int len, input string name);
    attempt(1'b0);
    check({name, "_fc1"}, failCount, 1);
    attempt(1'b0);
    check({name, "_fc2"}, failCount, 2);
    attempt(1'b0);
    check({name, "_state"}, stateCode, 2);
    check({name, "_len"}, remainingSeconds, len);
    check({name, "_key"}, keyEnable, 0);
    wait_cycles(len * CLK_HZ - 1);
    check({name, "_last_state"}, stateCode, 2);
    check({name, "_last_rem"}, remainingSeconds, 1);
    wait_cycles(1);
    check({name, "_exit_state"}, stateCode, 0);
    check({name, "_exit_pulse"}, relockPulse, 1);
    wait_cycles(1);
    check({name, "_pulse_drop"}, relockPulse, 0);
  endtask

  // Directed stimulus and checks
  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    attemptDone   = 1'b0;
    attemptPass   = 1'b0;
    relockRequest = 1'b0;

    // Reset
    wait_cycles(3);
    check("rst_key", keyEnable, 1);
    check("rst_state", stateCode, 0);
    reset = 1'b1;
    wait_cycles(1);
    check("rst_key_rel", keyEnable, 1);
    check("rst_state_rel", stateCode, 0);
    check("rst_fc", failCount, 0);
    check("rst_rem", remainingSeconds, 0);
    check("rst_pulse", relockPulse, 0);
    check("rst_unl", unlocked, 0);
    check("rst_lck", lockout, 0);

    // Pass, then hold expiry after exactly 100 cycles
    attempt(1'b1);
    check("pass_unl", unlocked, 1);
    check("pass_rem", remainingSeconds, 10);
    check("pass_key", keyEnable, 0);
    check("pass_state", stateCode, 1);
    wait_cycles(10);
    check("hold_rem_9", remainingSeconds, 9);
    wait_cycles(89);
    check("hold_last_state", stateCode, 1);
    check("hold_last_rem", remainingSeconds, 1);
    check("hold_no_pulse", relockPulse, 0);
    wait_cycles(1);
    check("hold_exit_state", stateCode, 0);
    check("hold_exit_pulse", relockPulse, 1);
    check("hold_exit_rem", remainingSeconds, 0);
    wait_cycles(1);
    check("hold_pulse_drop", relockPulse, 0);

    // Early relock after 25 cycles
    attempt(1'b1);
    wait_cycles(25);
    check("early_rem", remainingSeconds, 8);
    relock_once();
    check("early_state", stateCode, 0);
    check("early_pulse", relockPulse, 1);
    check("early_rem0", remainingSeconds, 0);
    check("early_key", keyEnable, 1);
    wait_cycles(1);
    check("early_single", relockPulse, 0);

    // First lockout; a stray attemptDone and a relockRequest are both ignored
    attempt(1'b0);
    check("lk1_fc1", failCount, 1);
    attempt(1'b0);
    check("lk1_fc2", failCount, 2);
    attempt(1'b0);
    check("lk1_state", stateCode, 2);
    check("lk1_rem", remainingSeconds, 5);
    check("lk1_key", keyEnable, 0);
    check("lk1_lck", lockout, 1);
    check("lk1_fc0", failCount, 0);
    attempt(1'b1);
    check("lk1_ignore_att", stateCode, 2);
    check("lk1_ignore_fc", failCount, 0);
    relock_once();
    check("lk1_ignore_relock", stateCode, 2);
    wait_cycles(47);
    check("lk1_last_state", stateCode, 2);
    check("lk1_last_rem", remainingSeconds, 1);
    wait_cycles(1);
    check("lk1_exit_state", stateCode, 0);
    check("lk1_exit_pulse", relockPulse, 1);
    wait_cycles(1);
    check("lk1_pulse_drop", relockPulse, 0);

    // Escalation, then saturation at 80 s
    do_lockout(10, "lk2");
    do_lockout(20, "lk3");
    do_lockout(40, "lk4");
    do_lockout(80, "lk5");
    do_lockout(80, "lk6");

    // A pass clears the escalation level
    attempt(1'b1);
    check("clear_unl", unlocked, 1);
    relock_once();
    check("clear_pulse", relockPulse, 1);
    wait_cycles(1);
    do_lockout(5, "lk_after_pass");

    // Reset in the middle of a lockout (level is 1 at this point)
    attempt(1'b0);
    attempt(1'b0);
    attempt(1'b0);
    check("mid_state", stateCode, 2);
    check("mid_len", remainingSeconds, 10);
    wait_cycles(70);
    check("mid_rem3", remainingSeconds, 3);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_state", stateCode, 0);
    check("mid_rst_key", keyEnable, 1);
    check("mid_rst_pulse", relockPulse, 0);
    check("mid_rst_rem", remainingSeconds, 0);
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(1);
    check("mid_rel_pulse", relockPulse, 0);
    do_lockout(5, "lk_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
